// File: rtl/sysid_info_regs.sv
// rtl/sysid_info_regs.sv - system ID / uptime / scratch / user-word register slave
module sysid_info_regs #(
  parameter logic [31:0] ID_VALUE  = 32'h56DE_A1FB,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int          NUM_USER  = 2,
  parameter logic [32*(NUM_USER > 0 ? NUM_USER : 1)-1:0] USER_WORDS = '0,
  parameter int          ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              waitrequest
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STAMP   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_INFO    = ADDR_W'(5);

  localparam logic [7:0]  NUM_USER_B = 8'(NUM_USER);
  localparam logic [31:0] INFO_WORD  = {16'h0001, 8'h00, NUM_USER_B};

  logic [63:0] uptime;
  logic [31:0] snapshot_hi;
  logic [31:0] scratch;
  logic [31:0] rd_word;

  // The slave answers every access in a fixed number of cycles.
  assign waitrequest = 1'b0;

  // Free-running uptime counter; wraps silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime <= 64'd0;
    end else begin
      uptime <= uptime + 64'd1;
    end
  end

  // Capture the high word whenever the low word is read so a lo/hi pair is coherent.
  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot_hi <= 32'd0;
    end else if (read && address == A_UP_LO) begin
      snapshot_hi <= uptime[63:32];
    end
  end

  // Byte-lane writes into the scratch register; all other addresses ignore writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= 32'd0;
    end else if (write && address == A_SCRATCH) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch[8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // Full-width address decode of the read word; unmapped addresses read zero.
  always_comb begin
    rd_word = 32'd0;
    if (address == A_ID) begin
      rd_word = ID_VALUE;
    end else if (address == A_STAMP) begin
      rd_word = TIMESTAMP;
    end else if (address == A_UP_LO) begin
      rd_word = uptime[31:0];
    end else if (address == A_UP_HI) begin
      rd_word = snapshot_hi;
    end else if (address == A_SCRATCH) begin
      rd_word = scratch;
    end else if (address == A_INFO) begin
      rd_word = INFO_WORD;
    end else begin
      for (int k = 0; k < NUM_USER; k++) begin
        if (address == ADDR_W'(6 + k)) begin
          rd_word = USER_WORDS[32*k +: 32];
        end
      end
    end
  end

  // Registered read response; data holds between reads, valid pulses once per read.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_sysid_info_regs.sv
// tb/tb_sysid_info_regs.sv - directed self-checking bench for sysid_info_regs
module tb_sysid_info_regs;

  localparam logic [31:0] ID_DEF = 32'h56DE_A1FB;

  logic        clock;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata0, readdata1;
  logic        readdatavalid0, readdatavalid1;
  logic        waitrequest0, waitrequest1;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] model_up;
  logic [31:0] exp_lo;

  sysid_info_regs dut0 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata0),
    .readdatavalid(readdatavalid0), .waitrequest(waitrequest0)
  );

  sysid_info_regs #(
    .NUM_USER(3),
    .USER_WORDS({32'hC, 32'hB, 32'hA}),
    .ADDR_W(4)
  ) dut1 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata1),
    .readdatavalid(readdatavalid1), .waitrequest(waitrequest1)
  );

  always #5 clock = ~clock;

  // Reference uptime: equals the DUT counter when observed at a falling edge.
  always @(posedge clock) begin
    if (reset) model_up <= 64'd0;
    else       model_up <= model_up + 64'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Single-cycle read issued at a falling edge, response checked at the next falling edge.
  task automatic rd(input logic [3:0] a, input string tag, input logic [31:0] e0,
                    input logic [31:0] e1, input bit chk1);
    address = a;
    read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    check({tag, "_v0"}, {31'd0, readdatavalid0}, 32'd1);
    check({tag, "_d0"}, readdata0, e0);
    if (chk1) begin
      check({tag, "_v1"}, {31'd0, readdatavalid1}, 32'd1);
      check({tag, "_d1"}, readdata1, e1);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a;
    writedata = d;
    byteenable = be;
    write = 1'b1;
    @(negedge clock);
    write = 1'b0;
    check("wr_no_valid", {31'd0, readdatavalid0}, 32'd0);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    address = 4'd0;
    writedata = 32'd0;
    byteenable = 4'd0;
    repeat (2) @(negedge clock);
    check("rst_rdata", readdata0, 32'd0);
    check("rst_valid", {31'd0, readdatavalid0}, 32'd0);
    check("waitreq", {31'd0, waitrequest0}, 32'd0);
    reset = 1'b0;

    rd(4'd3, "snap_rst", 32'd0, 32'd0, 1'b1);
    rd(4'd0, "id", ID_DEF, ID_DEF, 1'b1);
    rd(4'd1, "stamp", 32'd0, 32'd0, 1'b1);
    rd(4'd5, "info", 32'h0001_0002, 32'h0001_0003, 1'b1);

    wr(4'd4, 32'hDEAD_BEEF, 4'hF);
    wr(4'd4, 32'h0000_1200, 4'b0010);
    rd(4'd4, "scratch_be", 32'hDEAD_12EF, 32'hDEAD_12EF, 1'b1);

    address = 4'd4;
    writedata = 32'h1122_3344;
    byteenable = 4'hF;
    write = 1'b1;
    read = 1'b1;
    @(negedge clock);
    write = 1'b0;
    read = 1'b0;
    check("rw_valid", {31'd0, readdatavalid0}, 32'd1);
    check("rw_old", readdata0, 32'hDEAD_12EF);
    rd(4'd4, "rw_new", 32'h1122_3344, 32'h1122_3344, 1'b1);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rd(4'd4, "scratch_rst", 32'd0, 32'd0, 1'b1);

    reset = 1'b1;
    read = 1'b1;
    address = 4'd0;
    @(negedge clock);
    check("rst_read_nv", {31'd0, readdatavalid0}, 32'd0);
    reset = 1'b0;
    address = 4'd2;
    @(negedge clock);
    check("up0_v", {31'd0, readdatavalid0}, 32'd1);
    check("up0", readdata0, 32'd0);
    @(negedge clock);
    check("up1", readdata0, 32'd1);
    read = 1'b0;
    @(negedge clock);
    check("idle_nv", {31'd0, readdatavalid0}, 32'd0);
    check("idle_hold", readdata0, 32'd1);

    address = 4'd0;
    read = 1'b1;
    @(negedge clock);
    check("b2b0_v", {31'd0, readdatavalid0}, 32'd1);
    check("b2b0", readdata0, ID_DEF);
    address = 4'd1;
    @(negedge clock);
    check("b2b1_v", {31'd0, readdatavalid0}, 32'd1);
    check("b2b1", readdata0, 32'd0);
    address = 4'd2;
    exp_lo = model_up[31:0];
    @(negedge clock);
    check("b2b2_v", {31'd0, readdatavalid0}, 32'd1);
    check("b2b2", readdata0, exp_lo);
    address = 4'd0;
    @(negedge clock);
    check("b2b3_v", {31'd0, readdatavalid0}, 32'd1);
    check("b2b3", readdata0, ID_DEF);
    read = 1'b0;
    @(negedge clock);
    check("b2b_end_nv", {31'd0, readdatavalid0}, 32'd0);

    rd(4'd15, "unmapped15", 32'd0, 32'd0, 1'b1);
    wr(4'd0, 32'h1234_5678, 4'hF);
    rd(4'd0, "id_ro", ID_DEF, ID_DEF, 1'b1);
    rd(4'd6, "user6", 32'd0, 32'hA, 1'b1);
    rd(4'd7, "user7", 32'd0, 32'hB, 1'b1);
    rd(4'd8, "user8", 32'd0, 32'hC, 1'b1);
    rd(4'd9, "user9", 32'd0, 32'd0, 1'b1);

    address = 4'd2;
    read = 1'b1;
    force dut0.uptime = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut0.uptime;
    @(negedge clock);
    read = 1'b0;
    check("carry_lo_v", {31'd0, readdatavalid0}, 32'd1);
    check("carry_lo", readdata0, 32'hFFFF_FFFF);
    repeat (3) @(negedge clock);
    rd(4'd3, "carry_snap", 32'd0, 32'd0, 1'b0);
    rd(4'd2, "live_lo", 32'd4, 32'd0, 1'b0);
    rd(4'd3, "live_snap", 32'd1, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
- Parametrised successor to the fixed two-word system ID slave; Avalon-MM register slave on the Nios II system bus.
- Software uses it to identify the build and to check the bus.
- Provides ID and timestamp words, a 64-bit free-running uptime counter with atomic high-word snapshot, a byte-writable scratch register, and NUM_USER read-only words.
- Registered read path, fixed latency 1, readdatavalid handshake.

Parameters:
- ID_VALUE, 32'h56DE_A1FB, system ID word at address 0.
- TIMESTAMP, 32'h0000_0000, build timestamp word at address 1.
- NUM_USER, 2, number of user read-only words (0..8), at addresses 6.. (6+NUM_USER-1).
- USER_WORDS, {NUM_USER{32'h0}}, concatenated user word values; word k is USER_WORDS[32k+31:32k].
- ADDR_W, 4, word address width; must be at least ceil(log2(6+NUM_USER)).

Ports:
- clock, input, 1, system clock; all logic rising-edge.
- reset, input, 1, synchronous, active-high.
- address, input, ADDR_W, word address.
- read, input, 1, read strobe, single-cycle per access.
- write, input, 1, write strobe, single-cycle per access.
- writedata, input, 32, write data.
- byteenable, input, 4, byte lanes for writes.
- readdata, output, 32, registered read data.
- readdatavalid, output, 1, high for one cycle when readdata is valid.
- waitrequest, output, 1, tied 0; the slave never stalls.

Behaviour:
- Reset (reset=1 at a clock edge): readdata=0, readdatavalid=0, uptime=0, snapshot_hi=0, scratch=0. Reset overrides any read or write in the same cycle.
- Uptime: 64-bit counter, +1 every cycle when not in reset. Wraps from 2^64-1 to 0 with no flag.
- Address map:
  - 0: ID_VALUE, RO.
  - 1: TIMESTAMP, RO.
  - 2: UPTIME_LO, RO.
  - 3: UPTIME_HI_SNAP, RO.
  - 4: SCRATCH, RW.
  - 5: INFO, RO = {16'h0001 version, 8'h00, NUM_USER[7:0]}.
  - 6..5+NUM_USER: USER word (addr-6), RO.
  - All other addresses: read 0, writes ignored.
- Read latency:
  - read sampled at edge N; readdata and readdatavalid=1 are presented after edge N; readdatavalid drops after edge N+1 unless read is sampled again.
  - Back-to-back reads on consecutive cycles give one valid per cycle.
  - readdata holds its last value when readdatavalid=0.
- Snapshot:
  - A read of address 2 returns uptime[31:0] as sampled at edge N.
  - On the same edge, snapshot_hi loads uptime[63:32] from the same counter value.
  - A read of address 3 returns snapshot_hi, not the live high word. A low-then-high read pair is therefore atomic across a carry.
  - Reading address 3 without a prior address-2 read returns the last snapshot (0 after reset).
- Scratch write: when write=1 at an edge and address=4, each byte lane i with byteenable[i]=1 updates scratch[8i+7:8i]. Writes to RO or unmapped addresses have no effect and give no error.
- Simultaneous read and write (a protocol violation): the write takes effect and the read returns the old value. No readdatavalid is generated for write-only cycles.
- Reset mid-operation: a read sampled in the same cycle as reset produces no readdatavalid.
- Address decode uses the full ADDR_W bits; there is no aliasing.

Test Plan:
- Reset, then read addresses 0, 1, 5 with defaults -> readdata 32'h56DE_A1FB, 32'h0, 32'h0001_0002; each readdatavalid is exactly one cycle after its read.
- Write 32'hDEADBEEF to address 4 with byteenable 4'hF, then write 32'h0000_1200 with byteenable 4'b0010, then read address 4 -> 32'hDEAD12EF. Reset, then read address 4 -> 0.
- Force uptime to 64'h0000_0000_FFFF_FFFF (or run to it), read address 2 on that cycle, then read address 3 several cycles later -> 32'hFFFF_FFFF then 32'h0000_0000. The high-word snapshot is not the live value 1.
- Reads on 4 consecutive cycles of addresses 0, 1, 2, 0 -> readdatavalid high for 4 consecutive cycles with matching data. Read of address 15 -> 0. Write to address 0, then read address 0 -> still ID_VALUE.
- NUM_USER=3, USER_WORDS={32'hC,32'hB,32'hA} -> address 6 reads A, 7 reads B, 8 reads C, 9 reads 0; INFO low byte = 3.
- Assert read and reset on the same cycle -> no readdatavalid. Uptime reads 0 on the cycle after reset deasserts, and increments by 1 per cycle thereafter.
